uartin: RTL
===========

# uartin

Serial receiver for the chargen design: recovers 8-bit characters from the asynchronous `uart_rx` line and writes each one to a downstream FIFO through an active-low write strobe. It decodes the same frame the transmit path drives: one START bit (0), eight data bits MSB first (bit7 … bit0), one STOP bit (1), each bit `CDIV` clocks long. It sits between the board RX pin and the FIFO write port (`n_wr`, data, `n_full`).

## Interface
- `CDIV`, 2, clocks per bit; must be ≥ 2
- `clk`  in  1  system clock, all logic on rising edge
- `n_rst`  in  1  asynchronous reset, active-low
- `uart_rx`  in  1  serial line, idles high, asynchronous to `clk`
- `data_out`  out  8  last received character, held until the next valid one
- `n_wr`  out  1  FIFO write strobe, active-low, one clock per accepted character
- `n_full`  in  1  FIFO full, active-low
- `n_ferr`  out  1  framing error pulse, active-low, one clock
- `n_ovr`  out  1  overrun pulse, active-low, one clock (character dropped because FIFO full)
- `busy`  out  1  high from START detection until the frame completes

## Operation
- Reset (asynchronous, while `n_rst`=0): `data_out`=0, `n_wr`=1, `n_ferr`=1, `n_ovr`=1, `busy`=0, state IDLE. Synchronizer flops reset to 1 so the idle line never produces a false START.
- `uart_rx` goes through a 2-flop synchronizer. `rxs` is the synchronized value. A falling edge on `rxs` (previous 1, current 0) arms the receiver.
- States:
  - IDLE: falling edge on `rxs` → START. Load the bit-timer with `CDIV/2` (floor). Set `busy`=1.
  - START: when the timer expires, sample `rxs`. If 0 → DATA with bit index 7 and timer `CDIV`. If 1 (glitch) → IDLE with no output and no error.
  - DATA: at each timer expiry, shift `rxs` into the shift register MSB first and reload the timer with `CDIV`. After bit0 → STOP.
  - STOP: at timer expiry, sample `rxs`.
    - `rxs`=1 and `n_full`=1: `data_out`←shift register, `n_wr`=0 for one clock, → IDLE.
    - `rxs`=1 and `n_full`=0: `n_ovr`=0 for one clock, `data_out` unchanged, → IDLE.
    - `rxs`=0: `n_ferr`=0 for one clock, drop the character, → BREAK.
  - BREAK: wait for `rxs`=1, then → IDLE. A line held low never re-arms.
- `busy` is 0 in IDLE and 1 in every other state.
- The bit-timer is `$clog2(CDIV+1)` bits wide and counts down to 1. The bit index is 3 bits.

## Timing
- t = first rising edge at which the synchronized line is 0 while its previous value was 1. This is 2 clocks after `uart_rx` falls, relative to the edge that first captures it.
- START sample at t+`CDIV/2`.
- Data bit k (bit7 first, k=0…7) sampled at t+`CDIV/2`+(k+1)·`CDIV`.
- STOP sampled at t+`CDIV/2`+9·`CDIV`.
- `n_wr`, `n_ferr` or `n_ovr` is low during the clock after the STOP sample. `data_out` is valid in the same clock and holds afterwards.
- Back-to-back frames are supported: a falling edge in the clock after the STOP sample is accepted.
- `n_full` is sampled only at the STOP sample. FIFO state during the frame is irrelevant.
- Reset mid-frame aborts the frame with no strobes.

## Structure
- Shared package `uart_pkg`:
  - `UART_NBITS`=8
  - `UART_IDLE`=1'b1
  - state enum {IDLE, START, DATA, STOP, BREAK}, also usable by the transmitter
- Sub-module `sync2`: 2-flop synchronizer with asynchronous reset value parameter (default 1) and a falling-edge output.
- Top-level `top` instantiates `uartin` feeding the existing FIFO write port.

## Test plan
- Reset with `uart_rx`=1 → `n_wr`=1, `n_ferr`=1, `n_ovr`=1, `busy`=0, `data_out`=8'h00; no strobe for 50 clocks.
- `CDIV`=2, drive frame "a" (8'h61, MSB first) with `n_full`=1 → exactly one `n_wr` low pulse, `data_out`=8'h61 at t+1+9·2+1.
- Frames "a","b","c" back-to-back (no idle gap) → three `n_wr` pulses with `data_out` 8'h61, 8'h62, 8'h63 in order.
- `uart_rx` low for 1 clock only (`CDIV`=4) → no strobe, `busy` returns to 0 after 2 clocks.
- Frame 8'h7A with STOP bit 0, line held low 30 clocks, then frame 8'h41 → `n_ferr` pulse once, no `n_wr` for 8'h7A, then `n_wr` with 8'h41.
- Frame 8'h55 with `n_full`=0 at the STOP sample → `n_ovr` pulse, no `n_wr`, `data_out` keeps its previous value. Assert `n_rst` mid-frame → all outputs return to reset values immediately and no strobe follows.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   UART_NBITS   data bits per character
//   UART_IDLE    level of the idle line (also the STOP bit level)
//   uart_state_e frame state machine encoding
package uart_pkg;

  localparam int unsigned UART_NBITS = 8;
  localparam logic        UART_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input, plus a falling-edge
// detect on the synchronized value.
//   clk     system clock
//   n_rst   asynchronous reset, active-low (all flops load RstVal)
//   i_d     asynchronous input
//   o_q     synchronized value
//   o_fall  high while the synchronized value is 0 and its previous value was 1
module sync2 #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta <= RstVal;
      r_sync <= RstVal;
      r_prev <= RstVal;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_q    = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uartin.sv
// uartin: UART receiver. Recovers 8-bit characters (START 0, data MSB first,
// STOP 1, CDIV clocks per bit) from uart_rx and writes them to a FIFO.
//   CDIV      clocks per bit, must be >= 2
//   clk       system clock
//   n_rst     asynchronous reset, active-low
//   uart_rx   serial line, idles high, asynchronous to clk
//   data_out  last accepted character, held until the next one
//   n_wr      FIFO write strobe, active-low, one clock per accepted character
//   n_full    FIFO full, active-low, looked at only at the STOP sample
//   n_ferr    framing error pulse, active-low, one clock
//   n_ovr     overrun pulse (character dropped, FIFO full), active-low
//   busy      high from START detection until the frame completes
module uartin
  import uart_pkg::*;
#(
  parameter int unsigned CDIV = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  uart_rx,
  output logic [UART_NBITS-1:0] data_out,
  output logic                  n_wr,
  input  logic                  n_full,
  output logic                  n_ferr,
  output logic                  n_ovr,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(CDIV + 1);
  localparam logic [TW-1:0] TFull = TW'(CDIV);
  localparam logic [TW-1:0] THalf = TW'(CDIV / 2);
  localparam logic [TW-1:0] TOne  = TW'(1);
  localparam logic [2:0]    BitMsb = 3'(UART_NBITS - 1);

  logic w_rxs;
  logic w_fall;

  uart_state_e           r_state, w_state_d;
  logic [TW-1:0]         r_timer, w_timer_d;
  logic [2:0]            r_bidx, w_bidx_d;
  logic [UART_NBITS-1:0] r_shift, w_shift_d;
  logic [UART_NBITS-1:0] r_data, w_data_d;
  logic                  r_n_wr, w_n_wr_d;
  logic                  r_n_ferr, w_n_ferr_d;
  logic                  r_n_ovr, w_n_ovr_d;
  logic                  w_expire;

  // Reset to the idle level so a quiet line never looks like a START edge.
  sync2 #(
    .RstVal (UART_IDLE)
  ) u_sync2 (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_d    (uart_rx),
    .o_q    (w_rxs),
    .o_fall (w_fall)
  );

  assign w_expire = (r_timer == TOne);

  always_comb begin
    w_state_d  = r_state;
    w_timer_d  = r_timer;
    w_bidx_d   = r_bidx;
    w_shift_d  = r_shift;
    w_data_d   = r_data;
    w_n_wr_d   = 1'b1;
    w_n_ferr_d = 1'b1;
    w_n_ovr_d  = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_d = START;
          w_timer_d = THalf;  // land the samples mid-bit
        end
      end
      START: begin
        if (w_expire) begin
          if (w_rxs == UART_IDLE) begin
            w_state_d = IDLE;  // glitch shorter than half a bit
          end else begin
            w_state_d = DATA;
            w_bidx_d  = BitMsb;
            w_timer_d = TFull;
          end
        end else begin
          w_timer_d = r_timer - TOne;
        end
      end
      DATA: begin
        if (w_expire) begin
          w_shift_d = {r_shift[UART_NBITS-2:0], w_rxs};
          w_timer_d = TFull;
          if (r_bidx == 3'd0) begin
            w_state_d = STOP;
          end else begin
            w_bidx_d = r_bidx - 3'd1;
          end
        end else begin
          w_timer_d = r_timer - TOne;
        end
      end
      STOP: begin
        if (w_expire) begin
          if (w_rxs == UART_IDLE) begin
            w_state_d = IDLE;
            if (n_full) begin
              w_data_d = r_shift;
              w_n_wr_d = 1'b0;
            end else begin
              w_n_ovr_d = 1'b0;
            end
          end else begin
            w_state_d  = BREAK;
            w_n_ferr_d = 1'b0;
          end
        end else begin
          w_timer_d = r_timer - TOne;
        end
      end
      BREAK: begin
        // A line held low must return high before another START can arm.
        if (w_rxs == UART_IDLE) begin
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_bidx   <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_n_wr   <= 1'b1;
      r_n_ferr <= 1'b1;
      r_n_ovr  <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_timer  <= w_timer_d;
      r_bidx   <= w_bidx_d;
      r_shift  <= w_shift_d;
      r_data   <= w_data_d;
      r_n_wr   <= w_n_wr_d;
      r_n_ferr <= w_n_ferr_d;
      r_n_ovr  <= w_n_ovr_d;
    end
  end

  assign data_out = r_data;
  assign n_wr     = r_n_wr;
  assign n_ferr   = r_n_ferr;
  assign n_ovr    = r_n_ovr;
  assign busy     = (r_state != IDLE);

endmodule
